// File: rtl/rx_data_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rx_data_sequencer                                               |
// | Desc     : Receive packet sequencer: PID check, payload capture, length    |
// |            and CRC16 residue check, hold-until-ack handshake.              |
// |            Optional idle timeout enabled by defining RX_SEQ_TIMEOUT_EN.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rx_data_sequencer #(
    parameter int PAYLOAD_BITS   = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sop,
    input  logic                    bit_valid,
    input  logic                    in_bit,
    input  logic                    eop,
    input  logic [15:0]             crc_residue,
    input  logic                    pkt_ack,
    output logic                    crc_do,
    output logic                    crc_clr,
    output logic [3:0]              pid,
    output logic [PAYLOAD_BITS-1:0] data,
    output logic                    pkt_valid,
    output logic                    pkt_err,
    output logic [2:0]              err_code
);

    localparam int c_BUF_W = PAYLOAD_BITS + 16;
    localparam int c_CNT_W = $clog2(PAYLOAD_BITS + 18);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(PAYLOAD_BITS + 16);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(PAYLOAD_BITS + 17);
    localparam logic [15:0]        c_CRC_GOOD = 16'h800D;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_PID   = 3'd1;
    localparam logic [2:0] c_S_DATA  = 3'd2;
    localparam logic [2:0] c_S_CHECK = 3'd3;
    localparam logic [2:0] c_S_HOLD  = 3'd4;
    localparam logic [2:0] c_S_DRAIN = 3'd5;

    localparam logic [2:0] c_ERR_NONE    = 3'd0;
    localparam logic [2:0] c_ERR_PID     = 3'd1;
    localparam logic [2:0] c_ERR_LEN     = 3'd2;
    localparam logic [2:0] c_ERR_CRC     = 3'd3;
    localparam logic [2:0] c_ERR_OVERRUN = 3'd4;
    localparam logic [2:0] c_ERR_TIMEOUT = 3'd5;

    logic [2:0]              r_state;
    logic [2:0]              r_state_next;
    logic [6:0]              r_pid_sr;
    logic [2:0]              r_pid_cnt;
    logic [3:0]              r_pid_nib;
    logic [c_BUF_W-1:0]      r_buf;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic [2:0]              r_drain_code;
    logic [3:0]              r_pid;
    logic [PAYLOAD_BITS-1:0] r_data;
    logic                    r_pkt_err;
    logic [2:0]              r_err_code;

    logic [7:0] w_pid_byte;
    logic       w_pid_done;
    logic       w_pid_ok;
    logic       w_timeout;
    logic       w_err_fire;
    logic [2:0] w_err_code;
    logic       w_load_hold;

    assign w_pid_byte = {in_bit, r_pid_sr};
    assign w_pid_done = (r_state == c_S_PID) && bit_valid && !sop && (r_pid_cnt == 3'd7);
    assign w_pid_ok   = (w_pid_byte[3:0] == ~w_pid_byte[7:4]);

`ifdef RX_SEQ_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TO_W-1:0] r_idle_cnt;
    logic              w_rx_busy;

    assign w_rx_busy = (r_state == c_S_PID) || (r_state == c_S_DATA);
    // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a bit.
    assign w_timeout = w_rx_busy && !bit_valid && (r_idle_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (w_rx_busy && !bit_valid && !crc_clr && !w_timeout) begin
            r_idle_cnt <= r_idle_cnt + c_TO_W'(1);
        end else begin
            r_idle_cnt <= '0;
        end
    end
`else
    // Always false; TIMEOUT_CYCLES only matters when the idle counter exists.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (sop) r_state_next = c_S_PID;
            end
            c_S_PID: begin
                if (sop)             r_state_next = c_S_PID;
                else if (w_timeout)  r_state_next = c_S_IDLE;
                else if (w_pid_done) r_state_next = w_pid_ok ? c_S_DATA : c_S_DRAIN;
            end
            c_S_DATA: begin
                if (sop)            r_state_next = c_S_PID;
                else if (eop)       r_state_next = c_S_CHECK;
                else if (w_timeout) r_state_next = c_S_IDLE;
            end
            c_S_CHECK: begin
                if (sop) r_state_next = c_S_PID;
                else if ((r_bit_cnt == c_CNT_FULL) && (crc_residue == c_CRC_GOOD))
                    r_state_next = c_S_HOLD;
                else
                    r_state_next = c_S_IDLE;
            end
            c_S_HOLD: begin
                if (pkt_ack) r_state_next = sop ? c_S_PID : c_S_IDLE;
            end
            c_S_DRAIN: begin
                if (eop) r_state_next = c_S_IDLE;
            end
            default: r_state_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        crc_do      = 1'b0;
        crc_clr     = 1'b0;
        pkt_valid   = 1'b0;
        w_err_fire  = 1'b0;
        w_err_code  = c_ERR_NONE;
        w_load_hold = 1'b0;
        case (r_state)
            c_S_IDLE: crc_clr = sop;
            c_S_PID: begin
                if (sop) begin
                    crc_clr    = 1'b1;
                    w_err_fire = 1'b1;
                    w_err_code = c_ERR_LEN;
                end else if (w_timeout) begin
                    w_err_fire = 1'b1;
                    w_err_code = c_ERR_TIMEOUT;
                end
            end
            c_S_DATA: begin
                crc_do = bit_valid;
                if (sop) begin
                    crc_clr    = 1'b1;
                    w_err_fire = 1'b1;
                    w_err_code = c_ERR_LEN;
                end else if (!eop && w_timeout) begin
                    w_err_fire = 1'b1;
                    w_err_code = c_ERR_TIMEOUT;
                end
            end
            c_S_CHECK: begin
                w_err_fire = 1'b1;
                if (sop) begin
                    crc_clr    = 1'b1;
                    w_err_code = c_ERR_LEN;
                end else if (r_bit_cnt != c_CNT_FULL) begin
                    w_err_code = c_ERR_LEN;
                end else if (crc_residue != c_CRC_GOOD) begin
                    w_err_code = c_ERR_CRC;
                end else begin
                    w_err_fire  = 1'b0;
                    w_load_hold = 1'b1;
                end
            end
            c_S_HOLD: begin
                pkt_valid = 1'b1;
                if (sop && pkt_ack) begin
                    crc_clr = 1'b1;
                end else if (sop) begin
                    w_err_fire = 1'b1;
                    w_err_code = c_ERR_OVERRUN;
                end
            end
            c_S_DRAIN: begin
                if (eop) begin
                    w_err_fire = 1'b1;
                    w_err_code = r_drain_code;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pid_sr     <= '0;
            r_pid_cnt    <= '0;
            r_pid_nib    <= '0;
            r_buf        <= '0;
            r_bit_cnt    <= '0;
            r_drain_code <= c_ERR_NONE;
            r_pid        <= '0;
            r_data       <= '0;
            r_pkt_err    <= 1'b0;
            r_err_code   <= c_ERR_NONE;
        end else begin
            r_pkt_err <= w_err_fire;
            if (w_err_fire) r_err_code <= w_err_code;

            // A new packet start always restarts both bit counters.
            if (crc_clr) begin
                r_pid_cnt <= '0;
                r_bit_cnt <= '0;
            end else begin
                if ((r_state == c_S_PID) && bit_valid) begin
                    r_pid_sr  <= w_pid_byte[7:1];
                    r_pid_cnt <= r_pid_cnt + 3'd1;
                end
                if (crc_do) begin
                    r_buf <= {in_bit, r_buf[c_BUF_W-1:1]};
                    if (r_bit_cnt != c_CNT_SAT) r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                end
            end

            if (w_pid_done) begin
                r_pid_nib <= w_pid_byte[3:0];
                if (!w_pid_ok) r_drain_code <= c_ERR_PID;
            end

            if (w_load_hold) begin
                r_pid  <= r_pid_nib;
                r_data <= r_buf[PAYLOAD_BITS-1:0];
            end
        end
    end

    assign pid      = r_pid;
    assign data     = r_data;
    assign pkt_err  = r_pkt_err;
    assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_rx_data_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rx_data_sequencer                                            |
// | Desc     : Directed self-checking bench for rx_data_sequencer.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_rx_data_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sop = 1'b0;
    logic        bit_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        eop = 1'b0;
    logic [15:0] crc_residue = 16'h800D;
    logic        pkt_ack = 1'b0;
    logic        crc_do;
    logic        crc_clr;
    logic [3:0]  pid;
    logic [63:0] data;
    logic        pkt_valid;
    logic        pkt_err;
    logic [2:0]  err_code;

    localparam logic [63:0] c_DATA_A = 64'h0123456789ABCDEF;
    localparam logic [63:0] c_DATA_B = 64'hFEDCBA9876543210;
    localparam logic [63:0] c_DATA_C = 64'h5555AAAA3333CCCC;

    int         n_total = 0;
    int         n_bad = 0;
    int         err_pulses = 0;
    int         crc_do_cnt = 0;
    logic [2:0] last_code = 3'd0;
    int         e0;
    int         c0;

    rx_data_sequencer #(.PAYLOAD_BITS(64), .TIMEOUT_CYCLES(255)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .sop         (sop),
        .bit_valid   (bit_valid),
        .in_bit      (in_bit),
        .eop         (eop),
        .crc_residue (crc_residue),
        .pkt_ack     (pkt_ack),
        .crc_do      (crc_do),
        .crc_clr     (crc_clr),
        .pid         (pid),
        .data        (data),
        .pkt_valid   (pkt_valid),
        .pkt_err     (pkt_err),
        .err_code    (err_code)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (pkt_err) begin
            err_pulses = err_pulses + 1;
            last_code  = err_code;
        end
        if (crc_do) crc_do_cnt = crc_do_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [79:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            in_bit    = v[i];
            tick();
        end
        bit_valid = 1'b0;
        in_bit    = 1'b0;
    endtask

    task automatic start_pkt(input logic [7:0] pid_byte);
        sop = 1'b1;
        tick();
        sop = 1'b0;
        send_bits({72'd0, pid_byte}, 8);
    endtask

    task automatic eop_pulse();
        eop = 1'b1;
        tick();
        eop = 1'b0;
    endtask

    // Complete packet; returns with the sequencer in HOLD when all is good.
    task automatic full_pkt(input logic [7:0] pid_byte, input logic [63:0] d);
        start_pkt(pid_byte);
        send_bits({16'hBEEF, d}, 80);
        eop_pulse();
        tick();
    endtask

    task automatic ack();
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", pkt_valid, 0);
        chk("rst_err", pkt_err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_pid", pid, 0);
        chk("rst_data", data, 0);
        chk("rst_crc_do", crc_do, 0);
        chk("rst_crc_clr", crc_clr, 0);
        reset = 1'b0;
        tick();

        // Good DATA0 packet
        e0 = err_pulses;
        c0 = crc_do_cnt;
        sop = 1'b1;
        #1;
        chk("sop_clr", crc_clr, 1);
        tick();
        sop = 1'b0;
        send_bits({72'd0, 8'hC3}, 8);
        chk("pid_no_crc_do", crc_do_cnt - c0, 0);
        send_bits({16'hBEEF, c_DATA_A}, 80);
        eop_pulse();
        tick();
        chk("good_valid", pkt_valid, 1);
        chk("good_pid", pid, 4'h3);
        chk("good_data", data, c_DATA_A);
        chk("good_crc_do_cnt", crc_do_cnt - c0, 80);
        repeat (3) tick();
        chk("good_held", pkt_valid, 1);
        ack();
        chk("good_released", pkt_valid, 0);
        chk("good_no_err", err_pulses - e0, 0);

        // Bad PID drains until eop
        e0 = err_pulses;
        c0 = crc_do_cnt;
        start_pkt(8'hC4);
        send_bits({16'hBEEF, c_DATA_B}, 80);
        chk("badpid_no_early_err", err_pulses - e0, 0);
        eop_pulse();
        repeat (3) tick();
        chk("badpid_no_crc_do", crc_do_cnt - c0, 0);
        chk("badpid_err_cnt", err_pulses - e0, 1);
        chk("badpid_code", last_code, 1);
        chk("badpid_data_kept", data, c_DATA_A);

        // Short packet
        e0 = err_pulses;
        start_pkt(8'hC3);
        send_bits({16'd0, c_DATA_B}, 72);
        eop_pulse();
        repeat (3) tick();
        chk("short_err_cnt", err_pulses - e0, 1);
        chk("short_code", last_code, 2);
        chk("short_valid", pkt_valid, 0);

        // CRC failure
        e0 = err_pulses;
        crc_residue = 16'h1234;
        full_pkt(8'hC3, c_DATA_B);
        repeat (2) tick();
        crc_residue = 16'h800D;
        chk("crc_err_cnt", err_pulses - e0, 1);
        chk("crc_code", last_code, 3);
        chk("crc_data_kept", data, c_DATA_A);
        chk("crc_valid", pkt_valid, 0);

        // Overrun in HOLD, then sop with ack
        e0 = err_pulses;
        full_pkt(8'h4B, c_DATA_B);
        chk("hold_valid", pkt_valid, 1);
        chk("hold_pid", pid, 4'hB);
        chk("hold_data", data, c_DATA_B);
        sop = 1'b1;
        tick();
        sop = 1'b0;
        repeat (2) tick();
        chk("ovr_err_cnt", err_pulses - e0, 1);
        chk("ovr_code", last_code, 4);
        chk("ovr_still_valid", pkt_valid, 1);
        chk("ovr_data_kept", data, c_DATA_B);
        sop = 1'b1;
        pkt_ack = 1'b1;
        #1;
        chk("sopack_clr", crc_clr, 1);
        tick();
        sop = 1'b0;
        pkt_ack = 1'b0;
        chk("sopack_valid", pkt_valid, 0);
        send_bits({72'd0, 8'hC3}, 8);
        send_bits({16'hBEEF, c_DATA_A}, 80);
        eop_pulse();
        tick();
        chk("sopack_next_valid", pkt_valid, 1);
        chk("sopack_next_data", data, c_DATA_A);
        chk("sopack_no_err", err_pulses - e0, 1);
        ack();

        // sop aborts a packet in DATA and restarts
        e0 = err_pulses;
        start_pkt(8'hC3);
        send_bits({16'd0, c_DATA_B}, 10);
        sop = 1'b1;
        tick();
        sop = 1'b0;
        send_bits({72'd0, 8'hC3}, 8);
        send_bits({16'hBEEF, c_DATA_C}, 80);
        eop_pulse();
        tick();
        chk("abort_err_cnt", err_pulses - e0, 1);
        chk("abort_code", last_code, 2);
        chk("abort_restart_valid", pkt_valid, 1);
        chk("abort_restart_data", data, c_DATA_C);
        ack();

        // Long stall in DATA
        e0 = err_pulses;
        start_pkt(8'hC3);
        send_bits({16'hBEEF, c_DATA_B}, 40);
        repeat (300) tick();
        send_bits({16'hBEEF, c_DATA_B} >> 40, 40);
        eop_pulse();
        tick();
`ifdef RX_SEQ_TIMEOUT_EN
        chk("stall_err_cnt", err_pulses - e0, 1);
        chk("stall_code", last_code, 5);
        chk("stall_valid", pkt_valid, 0);
`else
        chk("stall_err_cnt", err_pulses - e0, 0);
        chk("stall_valid", pkt_valid, 1);
        chk("stall_data", data, c_DATA_B);
        ack();
`endif

        // Reset mid-packet
        e0 = err_pulses;
        start_pkt(8'hC3);
        send_bits({16'd0, c_DATA_A}, 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("rstmid_no_err", err_pulses - e0, 0);
        chk("rstmid_data", data, 0);
        chk("rstmid_pid", pid, 0);
        chk("rstmid_valid", pkt_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
